// File: rtl/jtsbaskt_obj_pkg.sv
// Shared types and constants for the Super Basketball object scanner.
package jtsbaskt_obj_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_CHECK,
        ST_OFFER,
        ST_DONE
    } obj_state_t;

    localparam int unsigned CODE = 0;
    localparam int unsigned ATTR = 1;
    localparam int unsigned XPOS = 2;
    localparam int unsigned YPOS = 3;

    localparam int unsigned HFLIP = 6;
    localparam int unsigned VFLIP = 7;

    localparam int unsigned SPR_H      = 16;
    localparam int unsigned LINE_LIMIT = 24;

endpackage

// File: rtl/jtsbaskt_objscan_if.sv
// Scanner-to-line-drawer handshake: decoded sprite parameters under valid/ready.
interface jtsbaskt_objscan_if;
    logic       draw_valid;
    logic       draw_ready;
    logic [7:0] draw_code;
    logic [3:0] draw_pal;
    logic       draw_hflip;
    logic       draw_vflip;
    logic [7:0] draw_x;
    logic [3:0] draw_ysub;

    modport master (
        output draw_valid, draw_code, draw_pal, draw_hflip, draw_vflip, draw_x, draw_ysub,
        input  draw_ready
    );

    modport slave (
        input  draw_valid, draw_code, draw_pal, draw_hflip, draw_vflip, draw_x, draw_ysub,
        output draw_ready
    );
endinterface

// File: rtl/jtsbaskt_objscan_fetch.sv
// Four-byte sprite entry reader: issues {bank,index,0..3} and captures the
// returned bytes one clock later; done pulses once the last byte is held.
module jtsbaskt_objscan_fetch
    import jtsbaskt_obj_pkg::*;
#(
    parameter int unsigned AW = 9
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          bank,
    input  logic [AW-4:0] index,
    output logic [AW-1:0] ram_addr,
    input  logic [7:0]    ram_data,
    output logic          done,
    output logic [7:0]    code,
    output logic [7:0]    attr,
    output logic [7:0]    xpos,
    output logic [7:0]    ypos
);
    logic [2:0] cnt;
    logic       active;
    logic [7:0] cap [4];
    logic [1:0] cidx;

    // cnt-2 is the byte whose data is on ram_data this cycle
    assign cidx = 2'(cnt - 3'd2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_addr <= '0;
            cnt      <= '0;
            active   <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) cap[i] <= '0;
        end else if (start) begin
            ram_addr <= {bank, index, 2'(CODE)};
            cnt      <= 3'd1;
            active   <= 1'b1;
        end else if (active) begin
            if (cnt < 3'd4) ram_addr[1:0] <= cnt[1:0];
            if (cnt >= 3'd2) cap[cidx] <= ram_data;
            if (cnt == 3'd5) active <= 1'b0;
            cnt <= cnt + 3'd1;
        end
    end

    assign done = active && (cnt == 3'd5);
    assign code = cap[2'(CODE)];
    assign attr = cap[2'(ATTR)];
    assign xpos = cap[2'(XPOS)];
    assign ypos = cap[2'(YPOS)];
endmodule

// File: rtl/jtsbaskt_objscan.sv
// Object line scanner: selects sprites crossing the current line and offers them
// to the drawer. Define JTSBASKT_OBJ_LIMIT_EN to cap hand-overs at 24 per line.
module jtsbaskt_objscan
    import jtsbaskt_obj_pkg::*;
#(
    parameter int unsigned NSPR = 64,
    parameter int unsigned AW   = 9
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pxl_cen,
    input  logic                 hinit,
    input  logic [7:0]           vrender,
    input  logic                 flip,
    input  logic                 obj_frame,
    output logic [AW-1:0]        ram_addr,
    input  logic [7:0]           ram_data,
    jtsbaskt_objscan_if.master   draw,
    output logic                 scan_busy,
    output logic [5:0]           hit_cnt
);
    localparam int unsigned IW = AW - 3;

    obj_state_t    st;
    logic          restart, last, hit, at_limit, vflip_n;
    logic          bank_l, flip_l, valid_q;
    logic          f_start, f_bank, f_done;
    logic [IW-1:0] idx, f_idx;
    logic [7:0]    veff, ydiff, code, attr, xpos, ypos;
    logic [7:0]    code_q, x_q;
    logic [3:0]    pal_q, ysub_q;
    logic          hflip_q, vflip_q;
    logic [1:0]    unused_attr;

    assign restart     = hinit & pxl_cen;
    assign last        = (idx == IW'(NSPR - 1));
    assign ydiff       = veff - ypos;
    assign hit         = (ydiff < 8'(SPR_H));
    assign vflip_n     = attr[VFLIP] ^ flip_l;
    assign unused_attr = attr[5:4];

`ifdef JTSBASKT_OBJ_LIMIT_EN
    assign at_limit = (hit_cnt == 6'(LINE_LIMIT - 1));
`else
    assign at_limit = 1'b0;
`endif

    // Next fetch is launched on the same edge that leaves CHECK/OFFER, so a
    // miss costs 6 clocks and a ready-high hit 7.
    always_comb begin
        f_start = 1'b0;
        f_bank  = bank_l;
        f_idx   = idx + IW'(1);
        if (restart) begin
            f_start = 1'b1;
            f_bank  = obj_frame;
            f_idx   = '0;
        end else if (st == ST_CHECK && !hit && !last) begin
            f_start = 1'b1;
        end else if (st == ST_OFFER && draw.draw_ready && !last && !at_limit) begin
            f_start = 1'b1;
        end
    end

    jtsbaskt_objscan_fetch #(.AW(AW)) u_fetch (
        .clk      (clk),
        .rst      (rst),
        .start    (f_start),
        .bank     (f_bank),
        .index    (f_idx),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .done     (f_done),
        .code     (code),
        .attr     (attr),
        .xpos     (xpos),
        .ypos     (ypos)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= ST_IDLE;
            bank_l    <= 1'b0;
            flip_l    <= 1'b0;
            veff      <= '0;
            idx       <= '0;
            hit_cnt   <= '0;
            scan_busy <= 1'b0;
            valid_q   <= 1'b0;
            code_q    <= '0;
            pal_q     <= '0;
            hflip_q   <= 1'b0;
            vflip_q   <= 1'b0;
            x_q       <= '0;
            ysub_q    <= '0;
        end else if (restart) begin
            st        <= ST_FETCH;
            bank_l    <= obj_frame;
            flip_l    <= flip;
            veff      <= flip ? ~vrender : vrender;
            idx       <= '0;
            hit_cnt   <= '0;
            scan_busy <= 1'b1;
            valid_q   <= 1'b0;
        end else begin
            case (st)
                ST_FETCH: if (f_done) st <= ST_CHECK;
                ST_CHECK: begin
                    if (hit) begin
                        st      <= ST_OFFER;
                        valid_q <= 1'b1;
                        code_q  <= code;
                        pal_q   <= attr[3:0];
                        hflip_q <= attr[HFLIP] ^ flip_l;
                        vflip_q <= vflip_n;
                        x_q     <= flip_l ? ~xpos : xpos;
                        ysub_q  <= ydiff[3:0] ^ {4{vflip_n}};
                    end else if (last) begin
                        st        <= ST_DONE;
                        scan_busy <= 1'b0;
                    end else begin
                        st  <= ST_FETCH;
                        idx <= idx + IW'(1);
                    end
                end
                ST_OFFER: begin
                    if (draw.draw_ready) begin
                        valid_q <= 1'b0;
                        hit_cnt <= hit_cnt + 6'd1;
                        if (last || at_limit) begin
                            st        <= ST_DONE;
                            scan_busy <= 1'b0;
                        end else begin
                            st  <= ST_FETCH;
                            idx <= idx + IW'(1);
                        end
                    end
                end
                ST_DONE: st <= ST_IDLE;
                default: st <= ST_IDLE;
            endcase
        end
    end

    // A restart withdraws a pending offer in the very cycle it is requested
    assign draw.draw_valid = valid_q & ~restart;
    assign draw.draw_code  = code_q;
    assign draw.draw_pal   = pal_q;
    assign draw.draw_hflip = hflip_q;
    assign draw.draw_vflip = vflip_q;
    assign draw.draw_x     = x_q;
    assign draw.draw_ysub  = ysub_q;
endmodule

// File: tb/tb_jtsbaskt_objscan.sv
// Scoreboard bench for jtsbaskt_objscan: expected offers are queued when a scan
// is launched and popped as the drawer handshake completes.
module tb_jtsbaskt_objscan;
    localparam int unsigned NSPR = 64;
    localparam int unsigned AW   = 9;
`ifdef JTSBASKT_OBJ_LIMIT_EN
    localparam int LIM = 24;
`else
    localparam int LIM = 30;
`endif

    logic          clk = 1'b0;
    logic          rst, pxl_cen, hinit, flip, obj_frame;
    logic [7:0]    vrender, ram_data;
    logic [AW-1:0] ram_addr;
    logic          scan_busy;
    logic [5:0]    hit_cnt;

    jtsbaskt_objscan_if draw_if ();

    jtsbaskt_objscan #(.NSPR(NSPR), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .pxl_cen   (pxl_cen),
        .hinit     (hinit),
        .vrender   (vrender),
        .flip      (flip),
        .obj_frame (obj_frame),
        .ram_addr  (ram_addr),
        .ram_data  (ram_data),
        .draw      (draw_if),
        .scan_busy (scan_busy),
        .hit_cnt   (hit_cnt)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [512];
    always @(posedge clk) ram_data <= mem[ram_addr];

    int n_chk = 0;
    int n_fail = 0;
    int busy_cnt = 0;
    int xfers = 0;
    int stalls = 0;
    logic [31:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [7:0] c, input logic [3:0] p, input logic h,
                                       input logic v, input logic [7:0] x, input logic [3:0] ys);
        return {6'd0, c, p, h, v, x, ys};
    endfunction

    task automatic set_spr(input logic bank, input int idx, input logic [7:0] c,
                           input logic [7:0] a, input logic [7:0] x, input logic [7:0] y);
        logic [5:0] i6;
        i6 = 6'(idx);
        mem[{bank, i6, 2'd0}] = c;
        mem[{bank, i6, 2'd1}] = a;
        mem[{bank, i6, 2'd2}] = x;
        mem[{bank, i6, 2'd3}] = y;
    endtask

    // Drawer ready: either a fixed level or toggling every 3 clocks
    logic tog_mode = 1'b0;
    logic rdy_fixed = 1'b0;
    int   tog_cnt = 0;
    always @(posedge clk) begin
        #1;
        if (tog_mode) begin
            tog_cnt++;
            if (tog_cnt == 3) begin
                tog_cnt = 0;
                draw_if.draw_ready = ~draw_if.draw_ready;
            end
        end else begin
            draw_if.draw_ready = rdy_fixed;
        end
    end

    logic        stall_prev = 1'b0;
    logic [31:0] held;
    always @(negedge clk) begin
        logic [31:0] cur;
        cur = mk(draw_if.draw_code, draw_if.draw_pal, draw_if.draw_hflip,
                 draw_if.draw_vflip, draw_if.draw_x, draw_if.draw_ysub);
        if (scan_busy === 1'b1) busy_cnt++;
        if (draw_if.draw_valid === 1'b1) begin
            if (stall_prev) begin
                chk("hold", cur, held);
                stalls++;
            end
            if (draw_if.draw_ready === 1'b1) begin
                xfers++;
                if (exp_q.size() == 0) chk("extra_offer", 32'd1, 32'd0);
                else chk("offer", cur, exp_q.pop_front());
                stall_prev = 1'b0;
            end else begin
                stall_prev = 1'b1;
                held = cur;
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    // Launch a scan; flip/frame/vrender are scrambled afterwards and must be ignored
    task automatic start_scan(input logic frame, input logic [7:0] vr, input logic fl);
        @(posedge clk); #1;
        busy_cnt = 0;
        hinit = 1'b1; pxl_cen = 1'b1; obj_frame = frame; vrender = vr; flip = fl;
        @(posedge clk);
        @(negedge clk);
        chk("first_addr", 32'(ram_addr), 32'({frame, 8'd0}));
        hinit = 1'b0; obj_frame = ~frame; flip = ~fl; vrender = ~vr;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (scan_busy === 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (scan_busy !== 1'b0) chk("done_timeout", 32'(scan_busy), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic push_bank1(input int n);
        for (int i = 0; i < n; i++) begin
            logic [7:0] iv;
            iv = 8'(i);
            exp_q.push_back(mk(8'h20 + iv, iv[3:0], iv[4], 1'b0, iv * 8'd3, iv[3:0]));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1; pxl_cen = 1'b0; hinit = 1'b0; flip = 1'b0; obj_frame = 1'b0; vrender = '0;
        for (int a = 0; a < 512; a++) mem[a] = (a % 4 == 3) ? 8'hA0 : 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(draw_if.draw_valid), 32'd0);
        chk("rst_busy", 32'(scan_busy), 32'd0);
        chk("rst_hitcnt", 32'(hit_cnt), 32'd0);
        chk("rst_addr", 32'(ram_addr), 32'd0);
        chk("rst_draw", mk(draw_if.draw_code, draw_if.draw_pal, draw_if.draw_hflip,
                           draw_if.draw_vflip, draw_if.draw_x, draw_if.draw_ysub), 32'd0);
        @(posedge clk); #1; rst = 1'b0;

        // hinit without pxl_cen must not start a scan
        @(posedge clk); #1; hinit = 1'b1; pxl_cen = 1'b0;
        @(posedge clk); #1; hinit = 1'b0; pxl_cen = 1'b1;
        @(negedge clk);
        chk("gated_hinit_busy", 32'(scan_busy), 32'd0);
        chk("gated_hinit_addr", 32'(ram_addr), 32'd0);

        // Single hit, ready high
        rdy_fixed = 1'b1;
        set_spr(1'b0, 5, 8'h12, 8'h43, 8'h80, 8'h40);
        exp_q.push_back(mk(8'h12, 4'h3, 1'b1, 1'b0, 8'h80, 4'h5));
        start_scan(1'b0, 8'h45, 1'b0);
        wait_done(2000);
        chk("hit_busy_cycles", 32'(busy_cnt), 32'd385);
        chk("hit_hitcnt", 32'(hit_cnt), 32'd1);
        chk("hit_pending", 32'(exp_q.size()), 32'd0);

        // Same sprite, line just below it
        start_scan(1'b0, 8'h50, 1'b0);
        wait_done(2000);
        chk("miss_busy_cycles", 32'(busy_cnt), 32'd384);
        chk("miss_hitcnt", 32'(hit_cnt), 32'd0);

        // Y wrap-around
        set_spr(1'b0, 5, 8'h12, 8'h43, 8'h80, 8'hF8);
        exp_q.push_back(mk(8'h12, 4'h3, 1'b1, 1'b0, 8'h80, 4'hB));
        start_scan(1'b0, 8'h03, 1'b0);
        wait_done(2000);
        chk("wrap_hitcnt", 32'(hit_cnt), 32'd1);
        chk("wrap_pending", 32'(exp_q.size()), 32'd0);

        // Flipped screen
        set_spr(1'b0, 5, 8'h12, 8'h43, 8'h80, 8'h40);
        exp_q.push_back(mk(8'h12, 4'h3, 1'b0, 1'b1, 8'h7F, 4'hA));
        start_scan(1'b0, 8'hBA, 1'b1);
        wait_done(2000);
        chk("flip_busy_cycles", 32'(busy_cnt), 32'd385);
        chk("flip_pending", 32'(exp_q.size()), 32'd0);

        // 30 hits in bank 1 with a stalling drawer
        for (int i = 0; i < 30; i++) begin
            logic [7:0] iv;
            iv = 8'(i);
            set_spr(1'b1, i, 8'h20 + iv, {1'b0, iv[4], 2'b00, iv[3:0]}, iv * 8'd3,
                    8'h45 - {4'd0, iv[3:0]});
        end
        push_bank1(LIM);
        xfers = 0; stalls = 0;
        tog_mode = 1'b1;
        start_scan(1'b1, 8'h45, 1'b0);
        wait_done(4000);
        chk("many_xfers", 32'(xfers), 32'(LIM));
        chk("many_hitcnt", 32'(hit_cnt), 32'(LIM));
        chk("many_pending", 32'(exp_q.size()), 32'd0);
        chk("many_stalls_seen", 32'(stalls > 0), 32'd1);

        // Restart while an offer is pending
        tog_mode = 1'b0; rdy_fixed = 1'b0;
        start_scan(1'b0, 8'h45, 1'b0);
        n = 0;
        while (draw_if.draw_valid !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("abort_pending", 32'(draw_if.draw_valid), 32'd1);
        repeat (3) @(negedge clk);
        push_bank1(LIM);
        @(posedge clk); #1;
        busy_cnt = 0;
        hinit = 1'b1; pxl_cen = 1'b1; obj_frame = 1'b1; vrender = 8'h45; flip = 1'b0;
        rdy_fixed = 1'b1;
        @(negedge clk);
        chk("abort_withdraw", 32'(draw_if.draw_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        hinit = 1'b0; obj_frame = 1'b0;
        chk("abort_addr", 32'(ram_addr), 32'h100);
        chk("abort_hitcnt", 32'(hit_cnt), 32'd0);
        wait_done(4000);
        chk("abort_rescan_hitcnt", 32'(hit_cnt), 32'(LIM));
        chk("abort_pending_q", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/jtsbaskt_objscan.md
# jtsbaskt_objscan

Sprite-table scanner placed directly upstream of the Super Basketball object line drawer. On each line start it walks the active bank of object RAM, selects the 16×16 sprites that intersect the line being rendered, and hands their decoded parameters one at a time to the drawer over a valid/ready handshake.

## Interface
- NSPR, 64: sprites per bank; 4 bytes each.
- AW, 9: RAM address width, {bank, sprite[5:0], byte[1:0]}.
- clk  in  1  48 MHz system clock; only clock.
- rst  in  1  asynchronous, active-high reset.
- pxl_cen  in  1  pixel clock enable; qualifies hinit.
- hinit  in  1  line start; sampled only when pxl_cen=1.
- vrender  in  8  line being rendered.
- flip  in  1  screen flip.
- obj_frame  in  1  active RAM bank; latched at scan start.
- ram_addr  out  AW  object RAM read address.
- ram_data  in  8  RAM data, valid exactly one clk after ram_addr.
- draw_valid  out  1  sprite parameters valid.
- draw_ready  in  1  drawer accepts; transfer when valid&ready.
- draw_code  out  8  tile code, byte 0.
- draw_pal  out  4  palette, byte 1 [3:0].
- draw_hflip  out  1  byte 1 bit 6, XOR flip.
- draw_vflip  out  1  byte 1 bit 7, XOR flip.
- draw_x  out  8  byte 2, or ~byte 2 when flip=1.
- draw_ysub  out  4  row within sprite.
- scan_busy  out  1  high from scan start to DONE.
- hit_cnt  out  6  sprites handed over this line.

## Operation
- States: IDLE, FETCH, CHECK, OFFER, DONE.
- IDLE -> FETCH on hinit&pxl_cen. Latch bank=obj_frame and veff = flip ? ~vrender : vrender. Clear index and hit_cnt.
- Scan order is index 0 to NSPR-1.
- FETCH: drive ram_addr={bank,index,b} for b=0..3 on consecutive clk cycles. Capture ram_data one cycle after each address.
- CHECK: ydiff = veff − byte3, modulo 256. Hit when ydiff<16.
  - Miss: advance index.
  - Hit: compute ysub = ydiff[3:0] ^ {4{draw_vflip}}, then go to OFFER.
- OFFER: draw_valid=1. All draw_* outputs are held stable until draw_ready. On transfer, hit_cnt++ and advance index.
- Advancing from index NSPR-1 goes to DONE. DONE goes to IDLE in one cycle and scan_busy drops.
- A new hinit&pxl_cen while busy aborts the current scan and restarts at FETCH with fresh latches. Any pending offer is withdrawn the same cycle (draw_valid=0).
- Changes to flip and obj_frame mid-scan are ignored until the next hinit.

## Timing
- Reset values: every output is 0 and the state is IDLE.
- hinit&pxl_cen to first ram_addr: 1 clk.
- A miss costs 6 clk: 4 addresses, 1 data tail, 1 CHECK.
- A hit costs 6 clk plus the wait for draw_ready. The fastest hit pair is offered at clk 6 and the next scan starts at clk 7.
- A full 64-sprite miss scan takes 384 clk, well inside a 3072-clk line.
- draw_ready held high makes OFFER last exactly 1 clk.
- Releasing reset mid-line leaves the block in IDLE until the next hinit.

## Configuration
- JTSBASKT_OBJ_LIMIT_EN:
  - Defined: at most 24 hits per line. After the 24th transfer the block goes straight to DONE, and the remaining sprites are neither read nor offered.
  - Undefined: no limit. hit_cnt can reach NSPR; with NSPR=64 and a 6-bit counter it wraps to 0.

## Structure
- Shared package jtsbaskt_obj_pkg holds:
  - state enum;
  - byte offsets (CODE=0, ATTR=1, XPOS=2, YPOS=3);
  - attribute bit positions (HFLIP=6, VFLIP=7);
  - sprite height 16;
  - line limit 24.
- Natural sub-module: jtsbaskt_objscan_fetch, the 4-byte address sequencer and capture registers, with start/done ports.

## Test plan
- Sprite 5 in bank 0: y=0x40, code=0x12, attr=0x43, x=0x80. vrender=0x45, flip=0, draw_ready=1 → exactly one offer: code 0x12, pal 3, hflip 1, vflip 0, x 0x80, ysub 5. hit_cnt=1.
- Same sprite with vrender=0x50 → no offer. scan_busy high for 384 clk.
- Wrap-around: y=0xF8, vrender=0x03 → hit with ysub 0xB.
- flip=1, vrender=0xBA (veff=0x45), x=0x80 → x 0x7F, hflip 0, vflip 1, ysub 0xA.
- 30 sprites all hit, draw_ready toggling every 3 clk:
  - outputs stay stable while valid&!ready;
  - with the macro, 24 offers;
  - without the macro, 30 offers.
- Second hinit&pxl_cen while OFFER is pending → draw_valid drops that clk. Next ram_addr is {new bank,0,0}. hit_cnt=0.
